// File: rtl/fwnoc_vc_fifo.sv
// fwnoc_vc_fifo: multi-virtual-channel flit buffer.
// NUM_VC independent ring FIFOs share one VC-steered ingress port and one
// round-robin arbitrated egress port. The egress grant locks while stalled so
// e_vc/e_dat stay stable until accepted.
module fwnoc_vc_fifo #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int NUM_VC    = 2,
   parameter int AFULL     = DEPTH - 1,
   parameter int VC_WIDTH  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
   parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [WIDTH-1:0]            i_dat,
   input  logic [VC_WIDTH-1:0]         i_vc,
   input  logic                        i_valid,
   output logic                        i_ready,
   output logic [WIDTH-1:0]            e_dat,
   output logic [VC_WIDTH-1:0]         e_vc,
   output logic                        e_valid,
   input  logic                        e_ready,
   output logic [NUM_VC*CNT_WIDTH-1:0] level,
   output logic [NUM_VC-1:0]           afull
);

   localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] AFULL_C  = CNT_WIDTH'(AFULL);
   localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
   localparam logic [VC_WIDTH-1:0]  VC_LAST  = VC_WIDTH'(NUM_VC - 1);

   logic [WIDTH-1:0]     mem   [NUM_VC][DEPTH];
   logic [PTR_WIDTH-1:0] rptr  [NUM_VC];
   logic [PTR_WIDTH-1:0] wptr  [NUM_VC];
   logic [CNT_WIDTH-1:0] count [NUM_VC];

   logic [VC_WIDTH-1:0]  rr_last;
   logic                 lock;
   logic [VC_WIDTH-1:0]  lock_vc;

   logic [VC_WIDTH-1:0]  vc_sel;
   logic                 vc_legal;
   logic [VC_WIDTH-1:0]  pick;
   logic [VC_WIDTH-1:0]  grant;
   logic                 any_valid;
   logic                 push;
   logic                 pop;
   logic [NUM_VC-1:0]    push_vc;
   logic [NUM_VC-1:0]    pop_vc;

   // Ingress VC decode: a single-VC buffer ignores the tag entirely.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      vc_sel   = '0;
      vc_legal = 1'b1;
      if (NUM_VC > 1) begin
         vc_sel   = i_vc;
         vc_legal = (int'(i_vc) < NUM_VC);
      end
   end

   // A full VC never accepts, even when it is being popped this cycle.
   assign i_ready = vc_legal && (count[vc_sel] < DEPTH_C);
   assign push    = i_valid && i_ready;

   // Egress is valid whenever any VC holds a flit.
   always_comb begin
      any_valid = 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (count[v] != '0) any_valid = 1'b1;
      end
   end

   // Round-robin pick: first non-empty VC after the last one served.
   always_comb begin : pick_logic
      logic found;
      int   idx;
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 1; off <= NUM_VC; off++) begin
         idx = (int'(rr_last) + off) % NUM_VC;
         if (!found && count[idx] != '0) begin
            pick  = VC_WIDTH'(idx);
            found = 1'b1;
         end
      end
   end

   assign grant   = lock ? lock_vc : pick;
   assign pop     = any_valid && e_ready;
   assign e_valid = any_valid;
   assign e_vc    = any_valid ? grant : '0;
   assign e_dat   = mem[grant][rptr[grant]];

   // Per-VC push/pop strobes.
   always_comb begin
      push_vc = '0;
      pop_vc  = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         push_vc[v] = push && (vc_sel == VC_WIDTH'(v));
         pop_vc[v]  = pop && (grant == VC_WIDTH'(v));
      end
   end

   // Flit storage write port.
   // NOTE: the data array has no reset; validity is tracked entirely by count.
   always_ff @(posedge clock) begin
      if (push) mem[vc_sel][wptr[vc_sel]] <= i_dat;
   end

   // Pointer and occupancy bookkeeping; pointers wrap explicitly at DEPTH-1.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int v = 0; v < NUM_VC; v++) begin
            rptr[v]  <= '0;
            wptr[v]  <= '0;
            count[v] <= '0;
         end
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (push_vc[v]) wptr[v] <= (wptr[v] == PTR_LAST) ? '0 : wptr[v] + PTR_WIDTH'(1);
            if (pop_vc[v])  rptr[v] <= (rptr[v] == PTR_LAST) ? '0 : rptr[v] + PTR_WIDTH'(1);
            case ({push_vc[v], pop_vc[v]})
               2'b10:   count[v] <= count[v] + CNT_WIDTH'(1);
               2'b01:   count[v] <= count[v] - CNT_WIDTH'(1);
               default: count[v] <= count[v];
            endcase
         end
      end
   end

   // Arbitration state: lock the grant while stalled, advance rr_last on pop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_last <= VC_LAST;
         lock    <= 1'b0;
         lock_vc <= '0;
      end else if (pop) begin
         lock    <= 1'b0;
         rr_last <= grant;
      end else if (any_valid) begin
         lock    <= 1'b1;
         lock_vc <= grant;
      end
   end

   // Occupancy and almost-full flags from the registered counts.
   always_comb begin
      level = '0;
      afull = '0;
      for (int k = 0; k < NUM_VC; k++) begin
         level[k*CNT_WIDTH +: CNT_WIDTH] = count[k];
         afull[k] = (count[k] >= AFULL_C);
      end
   end

   // A valid flit tagged for a nonexistent VC is an upstream bug; it is dropped.
   illegal_vc_a: assert property (@(posedge clock) disable iff (!reset_n) i_valid |-> vc_legal);

endmodule

// File: tb/tb_fwnoc_vc_fifo.sv
// Testbench for fwnoc_vc_fifo: scenario tasks plus randomized traffic, all
// checked against a queue-based reference model of the buffer.
module tb_fwnoc_vc_fifo;

   localparam int W  = 32;
   localparam int D  = 4;
   localparam int NV = 2;
   localparam int CW = 3;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [W-1:0]  i_dat;
   logic [0:0]    i_vc;
   logic          i_valid;
   logic          i_ready;
   logic [W-1:0]  e_dat;
   logic [0:0]    e_vc;
   logic          e_valid;
   logic          e_ready;
   logic [5:0]    level;
   logic [1:0]    afull;

   logic [W-1:0]  d3_i_dat;
   logic [0:0]    d3_i_vc;
   logic          d3_i_valid;
   logic          d3_i_ready;
   logic [W-1:0]  d3_e_dat;
   logic [0:0]    d3_e_vc;
   logic          d3_e_valid;
   logic          d3_e_ready;
   logic [3:0]    d3_level;
   logic [1:0]    d3_afull;

   fwnoc_vc_fifo #(.WIDTH(W), .DEPTH(D), .NUM_VC(NV)) dut (
      .clock(clock), .reset_n(reset_n),
      .i_dat(i_dat), .i_vc(i_vc), .i_valid(i_valid), .i_ready(i_ready),
      .e_dat(e_dat), .e_vc(e_vc), .e_valid(e_valid), .e_ready(e_ready),
      .level(level), .afull(afull)
   );

   fwnoc_vc_fifo #(.WIDTH(W), .DEPTH(3), .NUM_VC(NV)) dut3 (
      .clock(clock), .reset_n(reset_n),
      .i_dat(d3_i_dat), .i_vc(d3_i_vc), .i_valid(d3_i_valid), .i_ready(d3_i_ready),
      .e_dat(d3_e_dat), .e_vc(d3_e_vc), .e_valid(d3_e_valid), .e_ready(d3_e_ready),
      .level(d3_level), .afull(d3_afull)
   );

   always #5 clock = ~clock;

   // Reference model: one queue per VC, plus the "last served" VC and the
   // VC held on the egress port while a presented flit waits for acceptance.
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];
   int           m_last;
   bit           m_held;
   int           m_held_vc;

   int           n_cmp;
   int           n_err;
   logic [W-1:0] got_dat[$];
   int           got_vc[$];
   bit           last_acc;

   function automatic int m_size(input int v);
      return (v == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [W-1:0] m_head(input int v);
      return (v == 0) ? q0[0] : q1[0];
   endfunction

   function automatic int m_pick();
      int v;
      if (m_held) return m_held_vc;
      for (int o = 1; o <= NV; o++) begin
         v = (m_last + o) % NV;
         if (m_size(v) > 0) return v;
      end
      return 0;
   endfunction

   task automatic m_reset();
      q0.delete();
      q1.delete();
      m_last = NV - 1;
      m_held = 1'b0;
      m_held_vc = 0;
   endtask

   // One clock cycle of traffic on the main instance, checked against the model.
   task automatic cycle(input logic vld, input int vc, input logic [W-1:0] dat, input logic rdy);
      bit           exp_valid;
      bit           exp_ready;
      int           ev;
      logic [W-1:0] exp_dat;
      i_valid = vld;
      i_vc    = 1'(vc);
      i_dat   = dat;
      e_ready = rdy;
      #1;
      exp_valid = (m_size(0) + m_size(1)) > 0;
      ev        = exp_valid ? m_pick() : 0;
      exp_ready = m_size(vc) < D;
      exp_dat   = exp_valid ? m_head(ev) : '0;
      n_cmp++;
      if (e_valid !== exp_valid) begin
         n_err++;
         $display("FAIL e_valid: got %b expected %b at %0t", e_valid, exp_valid, $time);
      end
      n_cmp++;
      if (e_vc !== 1'(ev)) begin
         n_err++;
         $display("FAIL e_vc: got %0d expected %0d at %0t", e_vc, ev, $time);
      end
      if (exp_valid) begin
         n_cmp++;
         if (e_dat !== exp_dat) begin
            n_err++;
            $display("FAIL e_dat: got %h expected %h at %0t", e_dat, exp_dat, $time);
         end
      end
      n_cmp++;
      if (i_ready !== exp_ready) begin
         n_err++;
         $display("FAIL i_ready: got %b expected %b (vc %0d) at %0t", i_ready, exp_ready, vc, $time);
      end
      for (int k = 0; k < NV; k++) begin
         n_cmp++;
         if (level[k*CW +: CW] !== CW'(m_size(k))) begin
            n_err++;
            $display("FAIL level%0d: got %0d expected %0d at %0t", k, level[k*CW +: CW], m_size(k), $time);
         end
         n_cmp++;
         if (afull[k] !== (m_size(k) >= D - 1)) begin
            n_err++;
            $display("FAIL afull%0d: got %b expected %b at %0t", k, afull[k], (m_size(k) >= D - 1), $time);
         end
      end
      if (exp_valid && rdy) begin
         got_dat.push_back(e_dat);
         got_vc.push_back(int'(e_vc));
      end
      @(posedge clock);
      last_acc = vld && exp_ready;
      if (exp_valid && rdy) begin
         if (ev == 0) void'(q0.pop_front());
         else void'(q1.pop_front());
         m_last = ev;
         m_held = 1'b0;
      end else if (exp_valid) begin
         m_held = 1'b1;
         m_held_vc = ev;
      end
      if (last_acc) begin
         if (vc == 0) q0.push_back(dat);
         else q1.push_back(dat);
      end
      @(negedge clock);
   endtask

   task automatic drain();
      int b = 0;
      while ((m_size(0) + m_size(1)) > 0 && b < 50) begin
         cycle(1'b0, 0, '0, 1'b1);
         b++;
      end
      n_cmp++;
      if (e_valid !== 1'b0) begin
         n_err++;
         $display("FAIL drain: e_valid got %b expected 0", e_valid);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      for (int v = 0; v < NV; v++) begin
         i_vc = 1'(v);
         #1;
         n_cmp++;
         if (i_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_i_ready: vc %0d got %b expected 1", v, i_ready);
         end
      end
      n_cmp++;
      if (e_valid !== 1'b0 || e_vc !== 1'b0) begin
         n_err++;
         $display("FAIL reset_egress: e_valid/e_vc got %b/%0d expected 0/0", e_valid, e_vc);
      end
      n_cmp++;
      if (level !== '0 || afull !== '0) begin
         n_err++;
         $display("FAIL reset_level: level/afull got %h/%b expected 0/0", level, afull);
      end
      reset_n = 1'b1;
      m_reset();
      @(negedge clock);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) cycle(1'b1, 0, W'(32'hA0 + i), 1'b0);
      i_valid = 1'b0;
      i_vc = 1'b0;
      #1;
      n_cmp++;
      if (level[2:0] !== 3'd4 || afull[0] !== 1'b1 || i_ready !== 1'b0) begin
         n_err++;
         $display("FAIL fill_full: level0/afull0/i_ready got %0d/%b/%b expected 4/1/0", level[2:0], afull[0], i_ready);
      end
      i_vc = 1'b1;
      #1;
      n_cmp++;
      if (i_ready !== 1'b1) begin
         n_err++;
         $display("FAIL fill_vc1_ready: got %b expected 1", i_ready);
      end
      @(negedge clock);
      cycle(1'b1, 0, W'(32'hA4), 1'b0);
      n_cmp++;
      if (level[2:0] !== 3'd4) begin
         n_err++;
         $display("FAIL fill_overflow: level0 got %0d expected 4", level[2:0]);
      end
   endtask

   task automatic test_full_passthrough();
      int nxt = 4;
      got_dat.delete();
      got_vc.delete();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 0, W'(32'hA0 + nxt), 1'b1);
         if (last_acc) nxt++;
      end
      n_cmp++;
      if (level[2:0] !== 3'd3) begin
         n_err++;
         $display("FAIL pass_level: level0 got %0d expected 3", level[2:0]);
      end
      for (int i = 0; i < got_dat.size(); i++) begin
         n_cmp++;
         if (got_dat[i] !== W'(32'hA0 + i)) begin
            n_err++;
            $display("FAIL pass_order: flit %0d got %h expected %h", i, got_dat[i], 32'hA0 + i);
         end
      end
      drain();
   endtask

   task automatic test_round_robin();
      logic [W-1:0] exp_seq [6] = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12, 32'h22};
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 0, W'(32'h10 + i), 1'b0);
         cycle(1'b1, 1, W'(32'h20 + i), 1'b0);
      end
      got_dat.delete();
      got_vc.delete();
      for (int i = 0; i < 6; i++) cycle(1'b0, 0, '0, 1'b1);
      n_cmp++;
      if (got_dat.size() != 6) begin
         n_err++;
         $display("FAIL rr_count: got %0d flits expected 6", got_dat.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got_dat[i] !== exp_seq[i] || got_vc[i] != (i % 2)) begin
               n_err++;
               $display("FAIL rr_seq: slot %0d got %h/vc%0d expected %h/vc%0d", i, got_dat[i], got_vc[i], exp_seq[i], i % 2);
            end
         end
      end
      drain();
   endtask

   task automatic test_stall_lock();
      cycle(1'b1, 1, W'(32'h20), 1'b0);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (e_valid !== 1'b1 || e_vc !== 1'b1 || e_dat !== W'(32'h20)) begin
            n_err++;
            $display("FAIL stall_hold: cycle %0d got %b/%0d/%h expected 1/1/20", i, e_valid, e_vc, e_dat);
         end
         cycle(1'b1, 0, W'(32'h30 + i), 1'b0);
      end
      cycle(1'b0, 0, '0, 1'b1);
      n_cmp++;
      if (e_vc !== 1'b0 || e_dat !== W'(32'h30)) begin
         n_err++;
         $display("FAIL stall_next: got vc%0d/%h expected vc0/30", e_vc, e_dat);
      end
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0));
      end
      drain();
   endtask

   task automatic test_depth3();
      int           sent = 0;
      int           occ;
      int           budget = 0;
      bit           acc;
      bit           pop;
      logic [W-1:0] got;
      logic [W-1:0] rec[$];
      d3_i_vc = 1'b0;
      while (rec.size() < 10 && budget < 200) begin
         occ        = sent - rec.size();
         d3_i_valid = (sent < 10);
         d3_i_dat   = W'(sent + 1);
         d3_e_ready = ($urandom_range(0, 3) != 0);
         #1;
         n_cmp++;
         if (d3_level[1:0] !== 2'(occ) || d3_i_ready !== (occ < 3) || d3_e_valid !== (occ > 0)) begin
            n_err++;
            $display("FAIL d3_state: level/i_ready/e_valid got %0d/%b/%b expected %0d/%b/%b",
                     d3_level[1:0], d3_i_ready, d3_e_valid, occ, (occ < 3), (occ > 0));
         end
         acc = d3_i_valid && (occ < 3);
         pop = (occ > 0) && d3_e_ready;
         got = d3_e_dat;
         @(posedge clock);
         if (acc) sent++;
         if (pop) rec.push_back(got);
         @(negedge clock);
         budget++;
      end
      d3_i_valid = 1'b0;
      d3_e_ready = 1'b0;
      n_cmp++;
      if (rec.size() != 10) begin
         n_err++;
         $display("FAIL d3_budget: got %0d flits expected 10", rec.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (rec[i] !== W'(i + 1)) begin
               n_err++;
               $display("FAIL d3_order: flit %0d got %0d expected %0d", i, rec[i], i + 1);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 0, W'(32'h61), 1'b0);
      cycle(1'b1, 1, W'(32'h71), 1'b0);
      cycle(1'b1, 0, W'(32'h62), 1'b0);
      cycle(1'b1, 1, W'(32'h72), 1'b0);
      i_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (e_valid !== 1'b0 || level !== '0 || afull !== '0) begin
         n_err++;
         $display("FAIL midreset: e_valid/level/afull got %b/%h/%b expected 0/0/0", e_valid, level, afull);
      end
      m_reset();
      @(negedge clock);
      reset_n = 1'b1;
      cycle(1'b1, 1, W'(32'h55), 1'b0);
      n_cmp++;
      if (e_valid !== 1'b1 || e_vc !== 1'b1 || e_dat !== W'(32'h55)) begin
         n_err++;
         $display("FAIL midreset_push: got %b/vc%0d/%h expected 1/vc1/55", e_valid, e_vc, e_dat);
      end
      drain();
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      reset_n    = 1'b0;
      i_dat      = '0;
      i_vc       = '0;
      i_valid    = 1'b0;
      e_ready    = 1'b0;
      d3_i_dat   = '0;
      d3_i_vc    = '0;
      d3_i_valid = 1'b0;
      d3_e_ready = 1'b0;
      m_reset();
      test_reset();
      test_fill();
      test_full_passthrough();
      test_round_robin();
      test_stall_lock();
      test_random();
      test_depth3();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fwnoc_vc_fifo.md
# fwnoc_vc_fifo

Parametrised multi-virtual-channel flit buffer for fwnoc router input ports and network interfaces. It holds NUM_VC independent FIFOs of DEPTH entries and WIDTH bits each. A single ready/valid ingress port is steered by a VC tag. A single ready/valid egress port is shared by round-robin arbitration with grant lock. Per-VC occupancy and almost-full flags feed upstream credit/backpressure logic.

## Interface
- WIDTH, 32, flit data width in bits (>=1)
- DEPTH, 4, entries per VC (>=2; need not be a power of 2)
- NUM_VC, 2, number of virtual channels (>=1)
- AFULL, DEPTH-1, almost-full threshold per VC (1..DEPTH)
- VC_WIDTH, (NUM_VC>1)?$clog2(NUM_VC):1, VC tag width (derived)
- CNT_WIDTH, $clog2(DEPTH+1), per-VC occupancy width (derived)

- clock  in  1  sole clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_dat  in  WIDTH  ingress flit
- i_vc  in  VC_WIDTH  ingress target VC; values >= NUM_VC are illegal
- i_valid  in  1  ingress valid
- i_ready  out  1  selected VC (i_vc) has space
- e_dat  out  WIDTH  head flit of granted VC
- e_vc  out  VC_WIDTH  granted VC
- e_valid  out  1  any VC non-empty
- e_ready  in  1  egress accept
- level  out  NUM_VC*CNT_WIDTH  packed per-VC occupancy; VC k at [k*CNT_WIDTH +: CNT_WIDTH]
- afull  out  NUM_VC  afull[k] = (level_k >= AFULL)

## Operation
- Storage: NUM_VC rings of DEPTH x WIDTH. Each VC has its own rptr, wptr and count.
- Pointers wrap explicitly from DEPTH-1 to 0, so non-power-of-2 DEPTH works.
- i_ready = (count[i_vc] < DEPTH). It is combinational from i_vc and count. A full VC never accepts, even if the same cycle pops it (no pass-through).
- push = i_valid & i_ready: write i_dat at wptr[i_vc], advance wptr, count+1.
- pop = e_valid & e_ready: advance rptr[e_vc], count-1.
- Push and pop on the same VC in one cycle: both pointers advance and count is unchanged.
- Push and pop on different VCs are fully independent.
- Arbitration state:
  - rr_last register, reset NUM_VC-1.
  - lock flag plus lock_vc register, reset 0/0.
- Pick rule: the first non-empty VC scanning rr_last+1, rr_last+2, ... with modulo NUM_VC wrap.
- grant = lock ? lock_vc : pick.
- e_vc = grant, e_dat = head of VC grant, e_valid = |count.
- Grant lock:
  - If e_valid & !e_ready, set lock=1 and lock_vc=grant.
  - On pop, clear lock and set rr_last=grant.
  - So e_vc and e_dat stay stable while stalled.
  - A newly non-empty, higher-priority VC cannot preempt a stalled grant.
- When no VC is non-empty, e_vc = 0 and e_dat is don't-care. Lock is never set while e_valid=0.
- NUM_VC=1: arbitration degenerates; e_vc and i_vc are tied 0 and i_vc is ignored.
- Illegal i_vc: i_ready=0 and no state change. This must be assertion-checked in simulation.
- Data RAM is not reset. All pointers, counts, rr_last and lock are reset.

## Timing
- Reset (reset_n=0, asynchronous assert, synchronous-to-clock deassert by system) drives these outputs:
  - e_valid=0, e_vc=0
  - level all 0, afull all 0 (unless AFULL=0, which is disallowed)
  - i_ready=1 for any legal i_vc
- Latency: a flit pushed at edge N is presented at e_valid/e_dat after edge N (visible in cycle N+1) if its VC is granted. Minimum ingress-to-egress latency is 1 cycle.
- Throughput: one push and one pop per cycle, sustained, including on the same VC.
- level and afull are registered-count derived and update the cycle after the push or pop.
- Reset mid-operation discards all contents immediately: e_valid falls asynchronously and lock clears.
- Handshake rule: once e_valid=1, e_valid, e_vc and e_dat are held until pop.

## Test plan
- Reset, DEPTH=4, NUM_VC=2, push A0..A3 on VC0 with e_ready=0 -> level0 = 1,2,3,4; afull0 rises at 3; i_ready(vc0)=0 at 4; a 5th push (vc0) is not accepted; i_ready(vc1)=1.
- From full VC0, hold i_valid on VC0 with e_ready=1 -> i_ready stays 0 in the full cycle; from level 3 onward a simultaneous push/pop per cycle keeps level0=3; flits emerge A0,A1,... in order with no loss.
- Both VCs hold 3 flits (VC0: 0x10-0x12, VC1: 0x20-0x22), e_ready=1 -> egress sequence 0x10,0x20,0x11,0x21,0x12,0x22 with e_vc toggling 0,1.
- VC1 head 0x20 presented, e_ready=0 for 5 cycles while VC0 is filled -> e_vc=1 and e_dat=0x20 stable for 5 cycles; after accept the next grant is VC0.
- DEPTH=3 (non-power-of-2): push/pop 10 flits with sequential values 1..10 through VC0 -> output in order 1..10; pointers wrap 2->0; level never exceeds 3.
- Load 2 flits per VC, assert reset_n=0 mid-cycle -> e_valid=0 and level=0 immediately (before the next edge); after release, first push appears one cycle later with the correct data.
